bcd_stopwatch: RTL and testbench

Four-digit BCD stopwatch that produces the nibbles the board's seven-segment decoders (`ssd0`..`ssd5` family, one instance per HEX display) turn into segment patterns. It counts ticks derived from the board clock through a prescaler. Start/stop and clear come from push-button inputs that are synchronised and edge-detected here. It sits directly upstream of the decoders: each `digitN` output wires straight to one decoder's 4-bit `in`.

---
 rtl/bcd_stopwatch_pkg.sv | 30 +++
 rtl/bcd_stopwatch_digit.sv | 43 ++++
 rtl/bcd_stopwatch.sv | 176 +++++++++++++++++
 tb/tb_bcd_stopwatch.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch.
//
// Contents:
//   DIGIT_MAX        largest value a BCD digit may hold (9)
//   NUM_DIGITS       number of chained decade counters
//   state_t          run/stop state encoding (ST_STOPPED / ST_RUNNING)
//   calc_div()       clock cycles per count tick, CLK_HZ / TICK_HZ
//   presc_width()    bit width of a prescaler that counts 0..div-1
package stopwatch_defs;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  // Number of clk cycles per count tick. The caller must pick
  // frequencies that divide evenly and give a result of at least 2.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Width of the prescaler register. A divide-by-2 still needs one bit.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_digit.sv
// One decade (0..9) counter of the stopwatch digit chain.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset, clears q
//   clr    in   synchronous clear, overrides inc
//   inc    in   count enable (carry-in from the digit below, or the tick)
//   q      out  registered BCD value, always 0..9
//   carry  out  combinational carry-out: inc while q is 9
module bcd_digit
  import stopwatch_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_next;

  // Combinational so a carry ripples through every digit in one cycle.
  assign carry = inc & (q == DIGIT_MAX);

  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = 4'd0;
    end else if (inc) begin
      q_next = (q == DIGIT_MAX) ? 4'd0 : q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 4'd0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch feeding one seven-segment decoder per digit.
//
// Parameters:
//   CLK_HZ   input clock frequency in Hz
//   TICK_HZ  count rate in Hz; CLK_HZ / TICK_HZ must be an integer >= 2
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous active-high reset
//   btn_ss    in   start/stop push button, asynchronous level
//   btn_clr   in   clear push button, asynchronous level
//   digit0    out  least-significant BCD digit (registered)
//   digit1..3 out  higher BCD digits (registered)
//   running   out  1 while counting
//   overflow  out  sticky flag, set when the count wraps 9999 -> 0000
module bcd_stopwatch
  import stopwatch_defs::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       overflow
);

  localparam int            DIV        = calc_div(CLK_HZ, TICK_HZ);
  localparam int            PW         = presc_width(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  // ------------------------------------------------------------------
  // Button synchronisers and rising-edge detectors.
  // Bit 0 = start/stop, bit 1 = clear.
  // ------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;
  logic [1:0] prev_reg;
  logic [1:0] btn_event;
  logic       ss_event;
  logic       clr_event;

  assign btn_raw = {btn_clr, btn_ss};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 2'b00;
      sync2_reg <= 2'b00;
      prev_reg  <= 2'b00;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // One event per press however long the button is held: only the
  // low-to-high transition of the synchronised level counts.
  assign btn_event = sync2_reg & ~prev_reg;
  assign ss_event  = btn_event[0];
  assign clr_event = btn_event[1];

  // ------------------------------------------------------------------
  // Run/stop state machine. Clear never touches the state, so a
  // clear and a start/stop in the same cycle both take effect.
  // ------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_STOPPED;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (ss_event) begin
      state_next = (state_reg == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
    end
  end

  assign running = (state_reg == ST_RUNNING);

  // ------------------------------------------------------------------
  // Prescaler. Holds its value while stopped so a pause/resume keeps
  // the partially elapsed period.
  // ------------------------------------------------------------------
  logic [PW-1:0] presc_reg;
  logic [PW-1:0] presc_next;
  logic          tick;

  assign tick = running && (presc_reg == PRESC_LAST);

  always_comb begin
    presc_next = presc_reg;
    if (clr_event) begin
      presc_next = '0;
    end else if (running) begin
      presc_next = tick ? '0 : presc_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end

  // ------------------------------------------------------------------
  // Digit chain. carry_chain[0] is the tick; carry_chain[NUM_DIGITS]
  // fires only when every digit is 9 and a tick arrives, i.e. on the
  // 9999 -> 0000 wrap.
  // ------------------------------------------------------------------
  logic [NUM_DIGITS:0] carry_chain;
  logic [3:0]          digit_q [NUM_DIGITS];

  assign carry_chain[0] = tick;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_event),
        .inc   (carry_chain[gi]),
        .q     (digit_q[gi]),
        .carry (carry_chain[gi+1])
      );
    end
  endgenerate

  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];

  // ------------------------------------------------------------------
  // Sticky overflow flag. A clear beats a coincident wrap, matching
  // the digits, which are zeroed by the clear anyway.
  // ------------------------------------------------------------------
  logic overflow_reg;
  logic overflow_next;

  always_comb begin
    overflow_next = overflow_reg;
    if (clr_event) begin
      overflow_next = 1'b0;
    end else if (carry_chain[NUM_DIGITS]) begin
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= overflow_next;
    end
  end

  assign overflow = overflow_reg;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch.
// Instance "a" runs at DIV=10 for the directed and random scenarios;
// instance "b" runs at DIV=2 so the 9999 -> 0000 wrap is reachable.
// Both are compared against an integer-count reference model after
// every clock edge.
module tb_bcd_stopwatch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, ss_a = 1'b0, clr_a = 1'b0;
  logic [3:0] a_d0, a_d1, a_d2, a_d3;
  logic       a_run, a_ovf;

  logic       rst_b = 1'b1, ss_b = 1'b0, clr_b = 1'b0;
  logic [3:0] b_d0, b_d1, b_d2, b_d3;
  logic       b_run, b_ovf;

  bcd_stopwatch #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk      (clk),
    .reset    (rst_a),
    .btn_ss   (ss_a),
    .btn_clr  (clr_a),
    .digit0   (a_d0),
    .digit1   (a_d1),
    .digit2   (a_d2),
    .digit3   (a_d3),
    .running  (a_run),
    .overflow (a_ovf)
  );

  bcd_stopwatch #(.CLK_HZ(2), .TICK_HZ(1)) dut_fast (
    .clk      (clk),
    .reset    (rst_b),
    .btn_ss   (ss_b),
    .btn_clr  (clr_b),
    .digit0   (b_d0),
    .digit1   (b_d1),
    .digit2   (b_d2),
    .digit3   (b_d3),
    .running  (b_run),
    .overflow (b_ovf)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: elapsed count as a plain integer 0..9999.
  int m_count [2];
  int m_presc [2];
  int m_div   [2];
  bit m_run   [2];
  bit m_ovf   [2];
  // Recent samples of each button, index 0 = most recent clock edge.
  bit h_ss    [2][3];
  bit h_clr   [2][3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic model_reset(input int idx);
    m_count[idx] = 0;
    m_presc[idx] = 0;
    m_run[idx]   = 1'b0;
    m_ovf[idx]   = 1'b0;
    for (int j = 0; j < 3; j++) begin
      h_ss[idx][j]  = 1'b0;
      h_clr[idx][j] = 1'b0;
    end
  endtask

  // Called once per rising edge with the input levels present at it.
  // A press is acted on two edges after the edge that first sees it.
  task automatic model_edge(input int idx, input logic rst, input logic ss, input logic clr);
    bit ss_ev, clr_ev, tick;
    if (rst) begin
      model_reset(idx);
      return;
    end
    ss_ev  = h_ss[idx][1]  && !h_ss[idx][2];
    clr_ev = h_clr[idx][1] && !h_clr[idx][2];
    tick   = m_run[idx] && (m_presc[idx] == m_div[idx] - 1);
    if (clr_ev) begin
      m_count[idx] = 0;
      m_presc[idx] = 0;
      m_ovf[idx]   = 1'b0;
    end else begin
      if (m_run[idx]) m_presc[idx] = (m_presc[idx] + 1) % m_div[idx];
      if (tick) begin
        if (m_count[idx] == 9999) begin
          m_count[idx] = 0;
          m_ovf[idx]   = 1'b1;
        end else begin
          m_count[idx] = m_count[idx] + 1;
        end
      end
    end
    if (ss_ev) m_run[idx] = !m_run[idx];
    h_ss[idx][2]  = h_ss[idx][1];
    h_ss[idx][1]  = h_ss[idx][0];
    h_ss[idx][0]  = ss;
    h_clr[idx][2] = h_clr[idx][1];
    h_clr[idx][1] = h_clr[idx][0];
    h_clr[idx][0] = clr;
  endtask

  task automatic check_outputs();
    check_eq("a.state", {a_d3, a_d2, a_d1, a_d0, a_run, a_ovf},
             {to_bcd(m_count[0]), m_run[0], m_ovf[0]});
    check_eq("b.state", {b_d3, b_d2, b_d1, b_d0, b_run, b_ovf},
             {to_bcd(m_count[1]), m_run[1], m_ovf[1]});
  endtask

  // Advance one clock edge, update the model, compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge(0, rst_a, ss_a, clr_a);
    model_edge(1, rst_b, ss_b, clr_b);
    #1;
    check_outputs();
  endtask

  initial begin
    int op, hold, gap;
    m_div[0] = 10;
    m_div[1] = 2;
    model_reset(0);
    model_reset(1);

    // Reset and idle
    repeat (3) step();
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (50) step();
    check_eq("idle.digits", {a_d3, a_d2, a_d1, a_d0}, 16'h0000);
    check_eq("idle.running", a_run, 1'b0);
    check_eq("idle.overflow", a_ovf, 1'b0);
    $display("idle: 50 cycles, digits=%h%h%h%h", a_d3, a_d2, a_d1, a_d0);

    // Start: running rises two edges after the first sampling edge
    ss_a = 1'b1;
    step();
    check_eq("start.edge0", a_run, 1'b0);
    step();
    check_eq("start.edge1", a_run, 1'b0);
    step();
    check_eq("start.edge2", a_run, 1'b1);
    repeat (2) step();
    ss_a = 1'b0;
    repeat (7) step();
    check_eq("start.before_tick", a_d0, 4'd0);
    step();
    check_eq("start.first_tick", a_d0, 4'd1);
    repeat (110) step();
    check_eq("start.count12", {a_d3, a_d2, a_d1, a_d0}, 16'h0012);
    check_eq("start.one_toggle", a_run, 1'b1);
    $display("start: digits=%h%h%h%h running=%0b", a_d3, a_d2, a_d1, a_d0, a_run);

    // Pause four cycles into a period, then resume
    step();
    ss_a = 1'b1;
    repeat (3) step();
    ss_a = 1'b0;
    repeat (30) step();
    check_eq("pause.frozen", {a_d3, a_d2, a_d1, a_d0, a_run}, {16'h0012, 1'b0});
    ss_a = 1'b1;
    repeat (3) step();
    ss_a = 1'b0;
    repeat (5) step();
    check_eq("resume.5", {a_d3, a_d2, a_d1, a_d0}, 16'h0012);
    step();
    check_eq("resume.6", {a_d3, a_d2, a_d1, a_d0}, 16'h0013);
    $display("pause/resume: digits=%h%h%h%h", a_d3, a_d2, a_d1, a_d0);

    // Random button traffic
    for (int t = 0; t < 40; t++) begin
      op   = int'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 6));
      gap  = int'($urandom_range(2, 20));
      ss_a  = (op == 0 || op == 2);
      clr_a = (op == 1 || op == 2);
      repeat (hold) step();
      ss_a  = 1'b0;
      clr_a = 1'b0;
      repeat (gap) step();
      $display("txn %0d: op=%0d hold=%0d gap=%0d count=%0d running=%0b", t, op, hold, gap,
               m_count[0], m_run[0]);
    end

    // Clear lands on the cycle a tick is due
    if (!m_run[0]) begin
      ss_a = 1'b1;
      repeat (3) step();
      ss_a = 1'b0;
    end
    repeat (25) step();
    for (int i = 0; i < 20 && m_presc[0] != 7; i++) step();
    clr_a = 1'b1;
    repeat (3) step();
    check_eq("clr_tick.digits", {a_d3, a_d2, a_d1, a_d0}, 16'h0000);
    check_eq("clr_tick.running", a_run, 1'b1);
    clr_a = 1'b0;
    repeat (3) step();
    $display("clear on tick: digits=%h%h%h%h running=%0b", a_d3, a_d2, a_d1, a_d0, a_run);

    // Clear and start/stop together while running
    repeat (15) step();
    ss_a  = 1'b1;
    clr_a = 1'b1;
    repeat (3) step();
    check_eq("clr_ss.digits", {a_d3, a_d2, a_d1, a_d0}, 16'h0000);
    check_eq("clr_ss.running", a_run, 1'b0);
    ss_a  = 1'b0;
    clr_a = 1'b0;
    repeat (3) step();
    $display("clear+stop: digits=%h%h%h%h running=%0b", a_d3, a_d2, a_d1, a_d0, a_run);

    // Asynchronous reset at 0347 with a press in the synchroniser
    ss_a = 1'b1;
    repeat (3) step();
    ss_a = 1'b0;
    for (int i = 0; i < 5000 && m_count[0] != 347; i++) step();
    check_eq("pre_rst.digits", {a_d3, a_d2, a_d1, a_d0}, 16'h0347);
    ss_a = 1'b1;
    step();
    rst_a = 1'b1;
    #1;
    model_reset(0);
    check_eq("rst.async", {a_d3, a_d2, a_d1, a_d0, a_run, a_ovf}, 18'h0);
    ss_a = 1'b0;
    repeat (2) step();
    rst_a = 1'b0;
    repeat (10) step();
    check_eq("rst.no_toggle", a_run, 1'b0);
    $display("async reset: digits=%h%h%h%h running=%0b", a_d3, a_d2, a_d1, a_d0, a_run);

    // Fast instance: carry ripple and overflow
    ss_b = 1'b1;
    repeat (3) step();
    ss_b = 1'b0;
    for (int i = 0; i < 5000 && m_count[1] != 999; i++) step();
    check_eq("carry.0999", {b_d3, b_d2, b_d1, b_d0}, 16'h0999);
    for (int i = 0; i < 10 && m_count[1] == 999; i++) step();
    check_eq("carry.1000", {b_d3, b_d2, b_d1, b_d0}, 16'h1000);
    $display("carry: digits=%h%h%h%h", b_d3, b_d2, b_d1, b_d0);
    for (int i = 0; i < 20000 && m_count[1] != 9999; i++) step();
    check_eq("wrap.9999", {b_d3, b_d2, b_d1, b_d0, b_ovf}, {16'h9999, 1'b0});
    for (int i = 0; i < 10 && m_count[1] == 9999; i++) step();
    check_eq("wrap.0000", {b_d3, b_d2, b_d1, b_d0, b_ovf}, {16'h0000, 1'b1});
    repeat (20) step();
    check_eq("ovf.sticky", b_ovf, 1'b1);
    clr_b = 1'b1;
    repeat (3) step();
    clr_b = 1'b0;
    check_eq("ovf.clear", {b_d3, b_d2, b_d1, b_d0, b_ovf}, {16'h0000, 1'b0});
    check_eq("ovf.still_running", b_run, 1'b1);
    repeat (5) step();
    $display("overflow: overflow=%0b running=%0b", b_ovf, b_run);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
